// File: rtl/dsp_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_result_packer                                                          |
// | Tracks DSP_SLICE issues through a tag pipe, formats each P result          |
// | (shift/round/saturate) into an output FIFO; STALL returns credits.         |
// | Option macro: DSP_RESULT_ROUND_EN (round half toward +inf before shift).   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dsp_result_packer #(
  parameter int W3      = 48,
  parameter int WOUT    = 18,
  parameter int SHIFT   = 0,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            STALL,
  input  logic [W3-1:0]   P_IN,
  output logic [WOUT-1:0] OUT_DATA,
  output logic            OUT_SAT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [15:0]     SAT_CNT
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic signed [W3:0] c_MAX = {{(W3 + 2 - WOUT){1'b0}}, {(WOUT - 1){1'b1}}};
  localparam logic signed [W3:0] c_MIN = {{(W3 + 2 - WOUT){1'b1}}, {(WOUT - 1){1'b0}}};
`ifdef DSP_RESULT_ROUND_EN
  localparam int c_RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W3:0] c_RND = (SHIFT > 0) ? ({{W3{1'b0}}, 1'b1} << c_RND_SH) : '0;
`else
  localparam logic signed [W3:0] c_RND = '0;
`endif

  logic [LATENCY-1:0] r_tag;
  logic [c_AW-1:0]    r_wptr;
  logic [c_AW-1:0]    r_rptr;
  logic [c_CW-1:0]    r_count;
  logic [15:0]        r_sat_cnt;
  logic [WOUT:0]      r_mem [DEPTH];

  logic [31:0]        w_inflight;
  logic [31:0]        w_used;
  logic signed [W3:0] w_x;
  logic signed [W3:0] w_y;
  logic [WOUT-1:0]    w_data;
  logic               w_sat;
  logic               w_push;
  logic               w_pop;

  // Every tag still in the pipe already owns a FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_inflight = w_inflight + 32'(r_tag[k]);
    end
  end

  assign w_used = 32'(r_count) + w_inflight;
  assign STALL  = (w_used >= 32'(DEPTH));

  // One guard bit of headroom keeps the rounding add from wrapping.
  assign w_x = $signed({P_IN[W3-1], P_IN}) + c_RND;
  assign w_y = w_x >>> SHIFT;

  always_comb begin
    w_sat  = 1'b0;
    w_data = w_y[WOUT-1:0];
    if (w_y > c_MAX) begin
      w_sat  = 1'b1;
      w_data = c_MAX[WOUT-1:0];
    end else if (w_y < c_MIN) begin
      w_sat  = 1'b1;
      w_data = c_MIN[WOUT-1:0];
    end
  end

  assign w_push = r_tag[LATENCY-1] && (r_count != c_FULL);
  assign w_pop  = (r_count != '0) && OUT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tag     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_sat_cnt <= '0;
    end else begin
      r_tag[0] <= IN_VALID && !STALL;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CW'(1);
      end
      if (w_push && w_sat && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_sat, w_data};
    end
  end

  assign OUT_VALID          = (r_count != '0);
  assign {OUT_SAT, OUT_DATA} = OUT_VALID ? r_mem[r_rptr] : '0;
  assign SAT_CNT            = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dsp_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dsp_result_packer                                                       |
// | Directed-vector bench: SHIFT=0 instance plus a SHIFT=2 rounding instance.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dsp_result_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iv1, iv2, rdy1, rdy2;
  logic [47:0] p1, p2;
  logic        stall1, stall2, ov1, ov2, sat1, sat2;
  logic [17:0] d1, d2;
  logic [15:0] cnt1, cnt2;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  dsp_result_packer #(.W3(48), .WOUT(18), .SHIFT(0), .LATENCY(3), .DEPTH(4)) dut1 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv1), .STALL(stall1), .P_IN(p1),
    .OUT_DATA(d1), .OUT_SAT(sat1), .OUT_VALID(ov1), .OUT_READY(rdy1), .SAT_CNT(cnt1)
  );

  dsp_result_packer #(.W3(48), .WOUT(18), .SHIFT(2), .LATENCY(3), .DEPTH(4)) dut2 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv2), .STALL(stall2), .P_IN(p2),
    .OUT_DATA(d2), .OUT_SAT(sat2), .OUT_VALID(ov2), .OUT_READY(rdy2), .SAT_CNT(cnt2)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One issue, result presented on P_IN exactly LATENCY=3 edges later.
  task automatic issue(input bit sel, input logic [47:0] p);
    if (sel) iv2 = 1'b1; else iv1 = 1'b1;
    tick;
    iv1 = 1'b0;
    iv2 = 1'b0;
    p1  = 48'd999;
    p2  = 48'd999;
    tick;
    tick;
    if (sel) p2 = p; else p1 = p;
    tick;
    p1 = 48'd777;
    p2 = 48'd777;
  endtask

  logic [47:0] pv5 [8] = '{48'd0, 48'd0, 48'd0, 48'd10, 48'd11, 48'd12, 48'd99, 48'd13};
  bit          iv5 [8] = '{1, 1, 1, 0, 1, 0, 0, 0};

  initial begin
    RST = 1'b1; iv1 = 0; iv2 = 0; rdy1 = 0; rdy2 = 1; p1 = '0; p2 = '0;
    tick;
    chk("rst_valid", int'(ov1), 0);
    chk("rst_data", int'($signed(d1)), 0);
    chk("rst_sat", int'(sat1), 0);
    chk("rst_stall", int'(stall1), 0);
    chk("rst_satcnt", int'(cnt1), 0);
    RST = 1'b0;
    tick;

    // Single result, latency 3, idle P_IN never captured
    iv1 = 1'b1;
    tick;
    iv1 = 1'b0;
    p1 = 48'd999;
    tick;
    tick;
    chk("lat_not_early", int'(ov1), 0);
    p1 = 48'd12;
    tick;
    p1 = 48'd777;
    chk("lat_valid", int'(ov1), 1);
    chk("lat_data", int'($signed(d1)), 12);
    chk("lat_sat", int'(sat1), 0);
    rdy1 = 1'b1;
    tick;
    tick;
    tick;
    chk("idle_not_pushed", int'(ov1), 0);
    rdy1 = 1'b0;

    // Saturation both directions
    issue(0, 48'd200000);
    chk("satp_data", int'($signed(d1)), 131071);
    chk("satp_flag", int'(sat1), 1);
    rdy1 = 1'b1; tick; rdy1 = 1'b0;
    issue(0, -48'sd200000);
    chk("satn_data", int'($signed(d1)), -131072);
    chk("satn_flag", int'(sat1), 1);
    chk("sat_cnt", int'(cnt1), 2);
    rdy1 = 1'b1; tick; rdy1 = 1'b0;
    chk("sat_empty", int'(ov1), 0);

    // Back-pressure: IN_VALID held, STALL after 4 accepts, exactly 4 pushes
    for (int j = 1; j <= 12; j++) begin
      iv1 = 1'b1;
      p1  = 48'(j - 3);
      tick;
      if (j == 3) chk("bp_stall_lo", int'(stall1), 0);
      if (j == 4) chk("bp_stall_hi", int'(stall1), 1);
    end
    iv1 = 1'b0;
    chk("bp_stall_hold", int'(stall1), 1);
    chk("bp_head1", int'($signed(d1)), 1);
    rdy1 = 1'b1;
    tick;
    chk("bp_stall_drop", int'(stall1), 0);
    chk("bp_head2", int'($signed(d1)), 2);
    tick;
    chk("bp_head3", int'($signed(d1)), 3);
    tick;
    chk("bp_head4", int'($signed(d1)), 4);
    tick;
    chk("bp_no_fifth", int'(ov1), 0);
    rdy1 = 1'b0;

    // Push and pop on the same edge keep count and order
    for (int j = 0; j < 8; j++) begin
      iv1  = iv5[j];
      p1   = pv5[j];
      rdy1 = (j == 7);
      tick;
    end
    iv1 = 1'b0;
    chk("pp_head11", int'($signed(d1)), 11);
    tick;
    chk("pp_head12", int'($signed(d1)), 12);
    tick;
    chk("pp_head13", int'($signed(d1)), 13);
    tick;
    chk("pp_empty", int'(ov1), 0);
    rdy1 = 1'b0;

    // Shift by 2 with optional rounding
    issue(1, -48'sd6);
`ifdef DSP_RESULT_ROUND_EN
    chk("sh_neg6", int'($signed(d2)), -1);
`else
    chk("sh_neg6", int'($signed(d2)), -2);
`endif
    issue(1, 48'd6);
`ifdef DSP_RESULT_ROUND_EN
    chk("sh_pos6", int'($signed(d2)), 2);
`else
    chk("sh_pos6", int'($signed(d2)), 1);
`endif

    // Reset mid-stream with two ops in flight
    issue(0, 48'd55);
    chk("mid_pre_valid", int'(ov1), 1);
    iv1 = 1'b1;
    tick;
    tick;
    iv1 = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("mid_valid", int'(ov1), 0);
    chk("mid_data", int'($signed(d1)), 0);
    chk("mid_stall", int'(stall1), 0);
    chk("mid_satcnt", int'(cnt1), 0);
    RST = 1'b0;
    p1 = 48'd42;
    repeat (6) tick;
    chk("mid_discard", int'(ov1), 0);
    issue(0, 48'd7);
    chk("post_rst_valid", int'(ov1), 1);
    chk("post_rst_data", int'($signed(d1)), 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
